muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
Multicycle sequencer for the shared multiply/divide resource. It accepts one MULT/DIV request from the main control unit and checks for divide-by-zero. It then clears the selected arithmetic unit and counts its execution cycles. Finally it drives the HI/LO source select and the HI/LO write enable, and reports done or an exception back to the control unit. It sits between the control unit, the Mult/div units, the HI/LO input muxes and the HI/LO registers.

Parameters:
MULT_CYCLES, 32, number of RUN cycles the multiplier needs before HI/LO results are valid (1..63).
DIV_CYCLES, 32, number of RUN cycles the divider needs before HI/LO results are valid (1..63).
DATA_W, 32, operand width of the divisor input.
CNT_W, 6, cycle counter width; must hold max(MULT_CYCLES, DIV_CYCLES)-1.

Ports:
clk  in  1  system clock, all state changes on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request pulse from control unit, sampled only in IDLE
op_div  in  1  operation select at start: 0 = MULT, 1 = DIV
divisor  in  DATA_W  divisor operand (Reg_B value), sampled at start
abort  in  1  cancel any operation in progress
unit_clr  out  1  one-cycle synchronous clear to the selected arithmetic unit
div_or_mult  out  1  HI/LO input mux select: 1 = divider results, 0 = multiplier results
hilo_w  out  1  HI/LO register write enable, one-cycle pulse
busy  out  1  high while an operation or exception report is in flight
done  out  1  one-cycle completion pulse, coincident with hilo_w
div_zero  out  1  one-cycle divide-by-zero exception request

Behaviour:
- Reset (synchronous, active-high) forces state IDLE, counter 0, latched op 0. All outputs are 0 at the next edge. Reset has priority over every other input, including in mid-operation.
- States are IDLE, DZ, CLEAR, RUN, WRITE. All outputs are registered or decoded only from state; no output depends combinationally on start.
- IDLE: busy=0. On start=1 and abort=0:
  - if op_div=1 and divisor==0, go to DZ;
  - otherwise latch op_div, load counter with (op_div ? DIV_CYCLES : MULT_CYCLES)-1, and go to CLEAR.
  - start=0 keeps the block in IDLE. start with abort=1 in the same cycle is dropped.
- DZ: div_zero=1, busy=1 for exactly one cycle, then IDLE. hilo_w and done are never asserted; HI/LO are left unchanged.
- CLEAR: unit_clr=1, busy=1 for one cycle, then RUN.
- RUN: busy=1. The counter decrements each cycle. When counter==0, go to WRITE, so RUN lasts exactly N cycles.
- WRITE: hilo_w=1, done=1, busy=1 for one cycle, then IDLE.
- div_or_mult equals the latched op in every state. It holds its value after completion until the next accepted start and resets to 0.
- Latency: start accepted at cycle 0 gives CLEAR at cycle 1, RUN at cycles 2..N+1, and WRITE/done at cycle N+2. busy deasserts at N+3, and a new start is accepted at N+3.
- start while busy=1 is ignored and not queued. op_div and divisor changes while busy have no effect.
- abort=1 in DZ, CLEAR, RUN or WRITE forces IDLE at the next edge.
  - In WRITE, abort suppresses that cycle's hilo_w and done, because both are gated by ~abort.
  - In DZ, abort suppresses div_zero, which is also gated by ~abort.
  - abort in IDLE has no effect beyond dropping a simultaneous start.
- divisor==0 with op_div=0 is a normal MULT and raises no exception.
- Outputs unit_clr, hilo_w, done and div_zero are mutually exclusive pulses. No output is ever asserted for more than one consecutive cycle except busy and div_or_mult.

Test Plan:
- Reset, then MULT with MULT_CYCLES=32: start=1, op_div=0 at cycle 0 -> unit_clr=1 at cycle 1; hilo_w=done=1 only at cycle 34; div_or_mult=0 throughout; busy=1 for cycles 1..34.
- DIV with divisor=7, DIV_CYCLES=32: start at cycle 0 -> div_or_mult=1 from cycle 1; hilo_w=done=1 at cycle 34; div_zero never asserted.
- DIV with divisor=0: start at cycle 0 -> div_zero=1 at cycle 1 only; busy=1 at cycle 1 only; hilo_w, unit_clr and done stay 0; a new start at cycle 2 is accepted.
- Extra starts pulsed at cycles 5 and 34 during a MULT begun at cycle 0 -> no change to timing, a single hilo_w at 34; a start at cycle 35 is accepted (unit_clr at 36).
- abort at cycle 10 of a DIV begun at cycle 0 -> IDLE at 11, busy=0, and no hilo_w or done ever. Separately, abort coincident with WRITE (cycle 34) -> hilo_w=0 and done=0.
- reset asserted at cycle 20 of a MULT -> all outputs 0 at cycle 21; a start at cycle 22 produces unit_clr at 23 and hilo_w at 56.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multicycle sequencer for the shared multiply/divide resource.
// It accepts one MULT/DIV request, traps divide-by-zero, clears the selected unit,
// counts its RUN cycles, then pulses the HI/LO write enable and reports completion.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_reset        synchronous active-high reset
//   i_start        request pulse, only honoured in IDLE
//   i_op_div       operation at start: 0 = MULT, 1 = DIV
//   i_divisor      divisor operand, sampled at start
//   i_abort        cancel any operation in progress
//   o_unit_clr     one-cycle clear to the selected arithmetic unit
//   o_div_or_mult  HI/LO input mux select: 1 = divider, 0 = multiplier
//   o_hilo_w       HI/LO write enable pulse
//   o_busy         high while an operation or exception report is in flight
//   o_done         completion pulse, coincident with o_hilo_w
//   o_div_zero     divide-by-zero exception pulse
module muldiv_sequencer #(
  parameter int unsigned MULT_CYCLES = 32,
  parameter int unsigned DIV_CYCLES  = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned CNT_W       = 6
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_op_div,
  input  logic [DATA_W-1:0] i_divisor,
  input  logic              i_abort,
  output logic              o_unit_clr,
  output logic              o_div_or_mult,
  output logic              o_hilo_w,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_div_zero
);

  // RUN lasts N cycles: the counter is loaded with N-1 and RUN exits once it reads 0.
  localparam logic [CNT_W-1:0] MultLoad = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DivLoad  = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StDz,
    StClear,
    StRun,
    StWrite
  } state_e;

  state_e             r_state;
  state_e             w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_next;
  logic               r_op;
  logic               w_op_next;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_op    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_op    <= w_op_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_op_next    = r_op;
    case (r_state)
      StIdle: begin
        if (i_start && !i_abort) begin
          if (i_op_div && (i_divisor == '0)) begin
            // Exception path leaves the latched op (and so the HI/LO mux) untouched.
            w_state_next = StDz;
          end else begin
            w_op_next    = i_op_div;
            w_cnt_next   = i_op_div ? DivLoad : MultLoad;
            w_state_next = StClear;
          end
        end
      end
      StDz:    w_state_next = StIdle;
      StClear: w_state_next = StRun;
      StRun: begin
        if (r_cnt == '0) begin
          w_state_next = StWrite;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      StWrite: w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
    if (i_abort && (r_state != StIdle)) begin
      w_state_next = StIdle;
    end
  end

  // Output decode: from state only, with the write/exception pulses masked by abort.
  always_comb begin
    o_unit_clr = 1'b0;
    o_hilo_w   = 1'b0;
    o_done     = 1'b0;
    o_div_zero = 1'b0;
    o_busy     = (r_state != StIdle);
    case (r_state)
      StDz:    o_div_zero = ~i_abort;
      StClear: o_unit_clr = 1'b1;
      StWrite: begin
        o_hilo_w = ~i_abort;
        o_done   = ~i_abort;
      end
      default: ;
    endcase
  end

  assign o_div_or_mult = r_op;

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        op_div;
  logic [31:0] divisor;
  logic        abort;
  logic        unit_clr, div_or_mult, hilo_w, busy, done, div_zero;
  logic [5:0]  w_out;

  int n_chk  = 0;
  int n_pass = 0;

  muldiv_sequencer #(
    .MULT_CYCLES(32),
    .DIV_CYCLES (32),
    .DATA_W     (32),
    .CNT_W      (6)
  ) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_start      (start),
    .i_op_div     (op_div),
    .i_divisor    (divisor),
    .i_abort      (abort),
    .o_unit_clr   (unit_clr),
    .o_div_or_mult(div_or_mult),
    .o_hilo_w     (hilo_w),
    .o_busy       (busy),
    .o_done       (done),
    .o_div_zero   (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output bundle order: {unit_clr, div_or_mult, hilo_w, busy, done, div_zero}
  assign w_out = {unit_clr, div_or_mult, hilo_w, busy, done, div_zero};

  typedef struct packed {
    logic        rst;
    logic        start;
    logic        op;
    logic [31:0] div;
    logic        abort;
    logic [5:0]  exp;
  } vec_t;

  vec_t tbl [19];

  function automatic vec_t mk(logic r, logic s, logic o, logic [31:0] d, logic a,
                              logic [5:0] e);
    vec_t v;
    v.rst = r; v.start = s; v.op = o; v.div = d; v.abort = a; v.exp = e;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [5:0] act,
                     input logic [5:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got %b expected %b (clr,dom,hilo,busy,done,dz)",
                  name, idx, act, exp);
  endtask

  task automatic idle_in();
    reset = 1'b0; start = 1'b0; op_div = 1'b0; divisor = 32'd0; abort = 1'b0;
  endtask

  task automatic do_reset();
    idle_in();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Inputs for cycle c of scenario scn (cycle 0 = the start cycle).
  task automatic set_in(input int scn, input int c);
    idle_in();
    case (scn)
      0: begin
        if (c == 0 || c == 35) begin start = 1'b1; op_div = 1'b0; divisor = 32'd3; end
        if (c == 5 || c == 34) begin start = 1'b1; op_div = 1'b1; divisor = 32'd0; end
      end
      1: if (c == 0) begin start = 1'b1; op_div = 1'b1; divisor = 32'd7; end
      2: begin
        if (c == 0) begin start = 1'b1; op_div = 1'b1; divisor = 32'd7; end
        if (c == 10) abort = 1'b1;
      end
      3: begin
        if (c == 0) begin start = 1'b1; op_div = 1'b0; end
        if (c == 34) abort = 1'b1;
      end
      4: begin
        if (c == 0 || c == 22) begin start = 1'b1; op_div = 1'b0; divisor = 32'd11; end
        if (c == 20) reset = 1'b1;
      end
      default: ;
    endcase
  endtask

  // Hand-derived expectations from the latency rules (CLEAR at 1, WRITE at N+2 = 34).
  function automatic logic [5:0] exp_out(input int scn, input int c);
    logic clr, dom, hw, bsy;
    clr = 1'b0; dom = 1'b0; hw = 1'b0; bsy = 1'b0;
    case (scn)
      0: begin
        clr = (c == 1) || (c == 36);
        hw  = (c == 34);
        bsy = (c >= 1 && c <= 34) || (c >= 36);
      end
      1: begin
        clr = (c == 1); dom = (c >= 1); hw = (c == 34); bsy = (c >= 1 && c <= 34);
      end
      2: begin
        clr = (c == 1); dom = (c >= 1); bsy = (c >= 1 && c <= 10);
      end
      3: begin
        clr = (c == 1); bsy = (c >= 1 && c <= 34);
      end
      4: begin
        clr = (c == 1) || (c == 23);
        hw  = (c == 56);
        bsy = (c >= 1 && c <= 20) || (c >= 23 && c <= 56);
      end
      default: ;
    endcase
    return {clr, dom, hw, bsy, hw, 1'b0};
  endfunction

  task automatic run_scn(input string name, input int scn, input int ncyc);
    do_reset();
    for (int c = 0; c <= ncyc; c++) begin
      set_in(scn, c);
      #1;
      if (c > 0) chk(name, c, w_out, exp_out(scn, c));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // Per-cycle vectors: inputs applied during the cycle, outputs expected in that cycle.
    tbl[0]  = mk(0, 0, 0, 32'd0, 0, 6'b000000);  // reset state
    tbl[1]  = mk(0, 1, 1, 32'd0, 0, 6'b000000);  // DIV by zero requested
    tbl[2]  = mk(0, 1, 0, 32'd3, 0, 6'b000101);  // DZ pulse; start ignored
    tbl[3]  = mk(0, 0, 0, 32'd0, 0, 6'b000000);  // back in IDLE, nothing queued
    tbl[4]  = mk(0, 1, 0, 32'd0, 0, 6'b000000);  // MULT with divisor 0 is normal
    tbl[5]  = mk(0, 1, 1, 32'd0, 0, 6'b100100);  // CLEAR, start ignored
    tbl[6]  = mk(0, 0, 0, 32'd0, 1, 6'b000100);  // RUN, abort
    tbl[7]  = mk(0, 0, 0, 32'd0, 1, 6'b000000);  // IDLE, abort harmless
    tbl[8]  = mk(0, 1, 1, 32'd9, 1, 6'b000000);  // start+abort dropped
    tbl[9]  = mk(0, 0, 0, 32'd0, 0, 6'b000000);
    tbl[10] = mk(0, 1, 1, 32'd0, 0, 6'b000000);  // DIV by zero again
    tbl[11] = mk(0, 0, 0, 32'd0, 1, 6'b000100);  // DZ with abort: div_zero masked
    tbl[12] = mk(0, 0, 0, 32'd0, 0, 6'b000000);
    tbl[13] = mk(0, 1, 1, 32'd5, 0, 6'b000000);  // DIV by 5
    tbl[14] = mk(0, 0, 0, 32'd0, 0, 6'b110100);  // CLEAR, mux selects divider
    tbl[15] = mk(0, 0, 0, 32'd0, 0, 6'b010100);  // RUN
    tbl[16] = mk(1, 1, 0, 32'd0, 0, 6'b010100);  // reset raised, takes effect at edge
    tbl[17] = mk(0, 0, 0, 32'd0, 0, 6'b000000);  // all cleared
    tbl[18] = mk(0, 0, 0, 32'd0, 0, 6'b000000);

    do_reset();
    for (int i = 0; i < 19; i++) begin
      reset   = tbl[i].rst;
      start   = tbl[i].start;
      op_div  = tbl[i].op;
      divisor = tbl[i].div;
      abort   = tbl[i].abort;
      #1;
      chk("vec", i, w_out, tbl[i].exp);
      @(posedge clk);
      #1;
    end

    run_scn("mult_extra_starts", 0, 37);
    run_scn("div_by_7",          1, 36);
    run_scn("div_abort_run",     2, 40);
    run_scn("mult_abort_write",  3, 36);
    run_scn("mult_reset_mid",    4, 57);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
